// File: rtl/adc_scan_controller.sv
// adc_scan_controller: round-robin scan controller for an ADC0809-class converter.
// Drives the ALE/START/OE handshake, waits for a synchronized EOC (ignored for the
// first MIN_WAIT cycles, forced read after TIMEOUT cycles) and keeps one result
// register per channel with a one-cycle valid strobe.
// Optional feature: define ADC_SCAN_AVG_EN to replace the raw store with a
// per-channel first-order IIR filter (timed-out samples are not filtered in).
module adc_scan_controller #(
    parameter int NUM_CH   = 4,
    parameter int TIMEOUT  = 60,
    parameter int MIN_WAIT = 8
) (
    input  logic                  clk_500khz,
    input  logic                  rst_n,
    input  logic                  scan_en,
    output logic                  adc_clk,
    output logic                  adc_start,
    output logic                  adc_ale,
    output logic                  adc_oe,
    output logic [2:0]            adc_addr,
    input  logic                  adc_eoc,
    input  logic [7:0]            adc_data_in,
    output logic [8*NUM_CH-1:0]   ch_data,
    output logic                  sample_valid,
    output logic [2:0]            sample_ch,
    output logic [NUM_CH-1:0]     timeout_err
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
    localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t           state_q;
    logic             eoc_meta_q;
    logic             eoc_s_q;
    logic [2:0]       ch_idx_q;
    logic [2:0]       ch_idx_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             to_flag_q;
    logic             start_q;
    logic             ale_q;
    logic             oe_q;
    logic [2:0]       addr_q;
    logic [7:0]       ch_data_q [NUM_CH];
    logic             valid_q;
    logic [2:0]       sample_ch_q;
    logic [NUM_CH-1:0] terr_q;
    logic             eoc_ok;
    logic             wait_expired;
    logic             store_en;
    logic [7:0]       store_byte;

    // Two-flop synchronizer bringing the asynchronous EOC pin into the clock domain.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_500khz or negedge rst_n) begin
        if (!rst_n) begin
            eoc_meta_q <= 1'b0;
            eoc_s_q    <= 1'b0;
        end else begin
            eoc_meta_q <= adc_eoc;
            eoc_s_q    <= eoc_meta_q;
        end
    end

    // Next-value helpers: channel wrap, saturating wait counter and WAIT exit conditions.
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    always_comb begin
        ch_idx_d     = (ch_idx_q == LAST_CH) ? 3'd0 : ch_idx_q + 3'd1;
        wait_cnt_d   = (wait_cnt_q == TIMEOUT_C) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        eoc_ok       = (wait_cnt_q >= MIN_WAIT_C) && eoc_s_q;
        wait_expired = (wait_cnt_q == TIMEOUT_C);
    end

`ifdef ADC_SCAN_AVG_EN
    logic [7:0]        cur_byte;
    logic signed [9:0] diff;
    logic signed [9:0] filt;

    // IIR update y + ((x - y) >>> 2) in 10-bit signed, clamped back to a byte.
    always_comb begin
        cur_byte = 8'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx_q == 3'(k)) cur_byte = ch_data_q[k];
        end
        diff = $signed({2'b00, adc_data_in}) - $signed({2'b00, cur_byte});
        filt = $signed({2'b00, cur_byte}) + (diff >>> 2);
        if (filt < 10'sd0) begin
            store_byte = 8'd0;
        end else if (filt > 10'sd255) begin
            store_byte = 8'hFF;
        end else begin
            store_byte = filt[7:0];
        end
        // A forced read is untrusted, so it must not pull the filtered value.
        store_en = !to_flag_q;
    end
`else
    assign store_byte = adc_data_in;
    assign store_en   = 1'b1;
`endif

    // Scan FSM: all handshake pins and result registers are driven from flops.
    always_ff @(posedge clk_500khz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_idx_q    <= 3'd0;
            wait_cnt_q  <= '0;
            to_flag_q   <= 1'b0;
            start_q     <= 1'b0;
            ale_q       <= 1'b0;
            oe_q        <= 1'b0;
            addr_q      <= 3'd0;
            valid_q     <= 1'b0;
            sample_ch_q <= 3'd0;
            terr_q      <= '0;
            // NOTE: result registers are reset because the safe FSM may read them before the first scan.
            for (int k = 0; k < NUM_CH; k++) ch_data_q[k] <= 8'd0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    start_q <= 1'b0;
                    ale_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    if (scan_en) state_q <= S_ADDR;
                end
                S_ADDR: begin
                    addr_q     <= ch_idx_q;
                    ale_q      <= 1'b1;
                    start_q    <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    ale_q      <= 1'b0;
                    start_q    <= 1'b0;
                    wait_cnt_q <= wait_cnt_d;
                    // EOC is checked first so a simultaneous timeout is not flagged.
                    if (eoc_ok) begin
                        to_flag_q <= 1'b0;
                        oe_q      <= 1'b1;
                        state_q   <= S_READ;
                    end else if (wait_expired) begin
                        to_flag_q <= 1'b1;
                        oe_q      <= 1'b1;
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    // Bus settling cycle; OE already high since entry.
                    oe_q    <= 1'b1;
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_idx_q == 3'(k)) begin
                            if (store_en) ch_data_q[k] <= store_byte;
                            terr_q[k] <= to_flag_q;
                        end
                    end
                    oe_q        <= 1'b0;
                    valid_q     <= 1'b1;
                    sample_ch_q <= ch_idx_q;
                    ch_idx_q    <= ch_idx_d;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign adc_clk      = clk_500khz;
    assign adc_start    = start_q;
    assign adc_ale      = ale_q;
    assign adc_oe       = oe_q;
    assign adc_addr     = addr_q;
    assign sample_valid = valid_q;
    assign sample_ch    = sample_ch_q;
    assign timeout_err  = terr_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign ch_data[8*k +: 8] = ch_data_q[k];
    end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Testbench for adc_scan_controller: the bench plays the ADC (EOC timing, data per
// address) and predicts every conversion from the behavioural timing rules.
`timescale 1ns/1ps
module tb_adc_scan_controller;

    localparam int NCH = 4;
    localparam int TO  = 60;
    localparam int MW  = 8;

    typedef struct packed {
        logic [2:0]       addr;
        logic [7:0]       start_w;
        logic [7:0]       ale_w;
        logic [7:0]       oe_w;
        logic [7:0]       valid_w;
        logic [7:0]       lat;      // start cycle -> sample_valid cycle
        logic [7:0]       oe_lat;   // start cycle -> first OE cycle
        logic [2:0]       sample_ch;
        logic [8*NCH-1:0] ch_data;
        logic [NCH-1:0]   terr;
    } conv_t;

    logic             clk_500khz = 1'b0;
    logic             rst_n      = 1'b0;
    logic             scan_en    = 1'b0;
    logic             adc_eoc    = 1'b0;
    logic [7:0]       adc_data_in = 8'd0;
    logic             adc_clk;
    logic             adc_start;
    logic             adc_ale;
    logic             adc_oe;
    logic [2:0]       adc_addr;
    logic [8*NCH-1:0] ch_data;
    logic             sample_valid;
    logic [2:0]       sample_ch;
    logic [NCH-1:0]   timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]     data_tbl [8];
    logic [7:0]     exp_data [NCH];
    logic [NCH-1:0] exp_to;
    int             exp_ch;

    adc_scan_controller #(.NUM_CH(NCH), .TIMEOUT(TO), .MIN_WAIT(MW)) dut (
        .clk_500khz   (clk_500khz),
        .rst_n        (rst_n),
        .scan_en      (scan_en),
        .adc_clk      (adc_clk),
        .adc_start    (adc_start),
        .adc_ale      (adc_ale),
        .adc_oe       (adc_oe),
        .adc_addr     (adc_addr),
        .adc_eoc      (adc_eoc),
        .adc_data_in  (adc_data_in),
        .ch_data      (ch_data),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .timeout_err  (timeout_err)
    );

    always #1000 clk_500khz = ~clk_500khz;

    initial begin
        #(64'd2000 * 64'd60000);
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic string fmt(input conv_t c);
        return $sformatf("addr=%0d start_w=%0d ale_w=%0d oe_w=%0d valid_w=%0d lat=%0d oe_lat=%0d ch=%0d data=%h terr=%b",
                         c.addr, c.start_w, c.ale_w, c.oe_w, c.valid_w, c.lat, c.oe_lat,
                         c.sample_ch, c.ch_data, c.terr);
    endfunction

`ifdef ADC_SCAN_AVG_EN
    // Filter step from the arithmetic rule: floor((x - y) / 4) added to y, clamped.
    function automatic logic [7:0] iir(input logic [7:0] y, input logic [7:0] x);
        int diff, step, r;
        diff = int'(x) - int'(y);
        step = (diff >= 0) ? diff / 4 : -((-diff + 3) / 4);
        r    = int'(y) + step;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return 8'(r);
    endfunction
`endif

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) exp_data[k] = 8'd0;
        exp_to = '0;
        exp_ch = 0;
    endtask

    // Predicts one conversion. d = cycles after START before the ADC raises EOC, -1 = never.
    // EOC raised in start-relative cycle d is first visible to the controller at wait count d+2.
    task automatic model_step(input int d, output conv_t e);
        int  ch, je, jx;
        bit  to;
        ch = exp_ch;
        je = (d < 0) ? 100000 : d + 2;
        if (je <= TO) begin
            to = 1'b0;
            jx = (je > MW) ? je : MW;
        end else begin
            to = 1'b1;
            jx = TO;
        end
`ifdef ADC_SCAN_AVG_EN
        if (!to) exp_data[ch] = iir(exp_data[ch], data_tbl[ch]);
`else
        exp_data[ch] = data_tbl[ch];
`endif
        exp_to[ch] = to;
        e           = '0;
        e.addr      = 3'(ch);
        e.start_w   = 8'd1;
        e.ale_w     = 8'd1;
        e.oe_w      = 8'd2;
        e.valid_w   = 8'd1;
        e.lat       = 8'(jx + 3);
        e.oe_lat    = 8'(jx + 1);
        e.sample_ch = 3'(ch);
        for (int k = 0; k < NCH; k++) e.ch_data[8*k +: 8] = exp_data[k];
        e.terr      = exp_to;
        exp_ch      = (ch + 1) % NCH;
    endtask

    // Acts as the ADC for one conversion and records what the controller did.
    task automatic run_conv(input int d, input int drop_at, output conv_t o);
        int s_cyc, v_cyc;
        bit seen_s, seen_v;
        o      = '0;
        s_cyc  = 0;
        v_cyc  = 0;
        seen_s = 1'b0;
        seen_v = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk_500khz);
            adc_data_in = data_tbl[adc_addr];
            if (adc_start) begin
                if (!seen_s) begin
                    seen_s = 1'b1;
                    s_cyc  = cyc;
                    o.addr = adc_addr;
                end
                o.start_w = o.start_w + 8'd1;
            end
            if (adc_ale) o.ale_w = o.ale_w + 8'd1;
            if (adc_oe) begin
                if (o.oe_w == 8'd0 && seen_s) o.oe_lat = 8'(cyc - s_cyc);
                o.oe_w = o.oe_w + 8'd1;
            end
            if (sample_valid) begin
                if (!seen_v) begin
                    seen_v      = 1'b1;
                    v_cyc       = cyc;
                    o.lat       = 8'(cyc - s_cyc);
                    o.sample_ch = sample_ch;
                    o.ch_data   = ch_data;
                    o.terr      = timeout_err;
                end
                o.valid_w = o.valid_w + 8'd1;
            end
            if (seen_s) begin
                adc_eoc = (d >= 0) && (cyc - s_cyc >= d);
                if (cyc - s_cyc == drop_at) scan_en = 1'b0;
            end
            if (seen_v && cyc - v_cyc >= 1) break;
        end
        if (!seen_v) o = '1;
    endtask

    task automatic do_reset();
        @(negedge clk_500khz);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_500khz);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int starts;
        rst_n   = 1'b0;
        scan_en = 1'b0;
        for (int k = 0; k < 8; k++) data_tbl[k] = 8'($urandom_range(0, 255));
        model_reset();
        repeat (3) @(negedge clk_500khz);
        n_checks++;
        if ({adc_start, adc_ale, adc_oe, adc_addr, sample_valid, sample_ch, ch_data, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b ale=%b oe=%b addr=%0d valid=%b ch=%0d data=%h terr=%b, required all zero",
                     adc_start, adc_ale, adc_oe, adc_addr, sample_valid, sample_ch, ch_data, timeout_err);
        end
        n_checks++;
        if (adc_clk !== clk_500khz) begin
            n_fail++;
            $display("FAIL adc_clk_low: got %b required %b", adc_clk, clk_500khz);
        end
        @(posedge clk_500khz);
        #1;
        n_checks++;
        if (adc_clk !== clk_500khz) begin
            n_fail++;
            $display("FAIL adc_clk_high: got %b required %b", adc_clk, clk_500khz);
        end
        @(negedge clk_500khz);
        rst_n  = 1'b1;
        starts = 0;
        repeat (10) begin
            @(negedge clk_500khz);
            if (adc_start) starts++;
        end
        n_checks++;
        if (starts !== 0) begin
            n_fail++;
            $display("FAIL idle_without_scan_en: got %0d starts required 0", starts);
        end
    endtask

    task automatic test_single_conv();
        conv_t e, o;
        data_tbl[0] = 8'hA5;
        scan_en     = 1'b1;
        model_step(20, e);
        run_conv(20, -1, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL single_conv: got %s | required %s", fmt(o), fmt(e));
        end
        n_checks++;
`ifdef ADC_SCAN_AVG_EN
        if (o.ch_data[7:0] !== 8'h29) begin
`else
        if (o.ch_data[7:0] !== 8'hA5) begin
`endif
            n_fail++;
            $display("FAIL single_byte0: got %h", o.ch_data[7:0]);
        end
    endtask

    task automatic test_scan_wrap();
        conv_t e, o;
        int    d;
        data_tbl[0] = 8'h10;
        data_tbl[1] = 8'h20;
        data_tbl[2] = 8'h30;
        data_tbl[3] = 8'h40;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(10, 40);
            model_step(d, e);
            run_conv(d, -1, o);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_conv%0d: got %s | required %s", i, fmt(o), fmt(e));
            end
        end
        n_checks++;
`ifdef ADC_SCAN_AVG_EN
        if (ch_data !== 32'h100C0804) begin
`else
        if (ch_data !== 32'h40302010) begin
`endif
            n_fail++;
            $display("FAIL wrap_ch_data: got %h", ch_data);
        end
        d = $urandom_range(10, 40);
        model_step(d, e);
        run_conv(d, -1, o);
        n_checks++;
        if (o.addr !== 3'd0 || o !== e) begin
            n_fail++;
            $display("FAIL wrap_fifth: got %s | required %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_timeout();
        conv_t e, o;
        int    d;
        do_reset();
        data_tbl[2] = 8'h77;
        while (exp_ch != 2) begin
            d = $urandom_range(5, 30);
            model_step(d, e);
            run_conv(d, -1, o);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_pre: got %s | required %s", fmt(o), fmt(e));
            end
        end
        model_step(-1, e);
        run_conv(-1, -1, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL timeout_conv: got %s | required %s", fmt(o), fmt(e));
        end
        n_checks++;
`ifdef ADC_SCAN_AVG_EN
        if (o.lat !== 8'd63 || o.terr[2] !== 1'b1 || o.ch_data[23:16] !== 8'h00) begin
`else
        if (o.lat !== 8'd63 || o.terr[2] !== 1'b1 || o.ch_data[23:16] !== 8'h77) begin
`endif
            n_fail++;
            $display("FAIL timeout_fields: got lat=%0d terr2=%b byte2=%h", o.lat, o.terr[2], o.ch_data[23:16]);
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(5, 30);
            model_step(d, e);
            run_conv(d, -1, o);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_post%0d: got %s | required %s", i, fmt(o), fmt(e));
            end
        end
        n_checks++;
        if (timeout_err[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got timeout_err[2]=%b required 0", timeout_err[2]);
        end
    endtask

    task automatic test_early_eoc();
        conv_t e, o;
        model_step(0, e);
        run_conv(0, -1, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL early_conv: got %s | required %s", fmt(o), fmt(e));
        end
        n_checks++;
        if (o.oe_lat !== 8'(MW + 1)) begin
            n_fail++;
            $display("FAIL early_read_time: got oe_lat=%0d required %0d", o.oe_lat, MW + 1);
        end
    endtask

    task automatic test_boundaries();
        conv_t e, o;
        int    ds [5];
        int    d;
        ds = '{MW - 2, MW - 1, TO - 2, TO - 1, 70};
        for (int i = 0; i < 11; i++) begin
            if (i < 5) d = ds[i];
            else d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 70));
            model_step(d, e);
            run_conv(d, -1, o);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL boundary_d%0d: got %s | required %s", d, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_scan_en_drop();
        conv_t e, o;
        int    d, starts;
        while (exp_ch != 1) begin
            d = $urandom_range(5, 30);
            model_step(d, e);
            run_conv(d, -1, o);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL drop_pre: got %s | required %s", fmt(o), fmt(e));
            end
        end
        model_step(30, e);
        run_conv(30, 4, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL drop_completes: got %s | required %s", fmt(o), fmt(e));
        end
        starts = 0;
        repeat (30) begin
            @(negedge clk_500khz);
            if (adc_start) starts++;
        end
        n_checks++;
        if (starts !== 0) begin
            n_fail++;
            $display("FAIL drop_idles: got %0d starts required 0", starts);
        end
        scan_en = 1'b1;
        model_step(15, e);
        run_conv(15, -1, o);
        n_checks++;
        if (o.addr !== 3'd2 || o !== e) begin
            n_fail++;
            $display("FAIL drop_resume: got %s | required %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_abort();
        bit found;
        found   = 1'b0;
        scan_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_500khz);
            adc_data_in = data_tbl[adc_addr];
            adc_eoc     = 1'b1;
            if (adc_oe) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_oe_seen: got no adc_oe within 200 cycles, required adc_oe high");
        end
        #100;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({adc_start, adc_ale, adc_oe, adc_addr, sample_valid, sample_ch, ch_data, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got oe=%b addr=%0d valid=%b ch=%0d data=%h terr=%b, required all zero",
                     adc_oe, adc_addr, sample_valid, sample_ch, ch_data, timeout_err);
        end
        model_reset();
        @(negedge clk_500khz);
        rst_n = 1'b1;
    endtask

    task automatic test_average();
`ifdef ADC_SCAN_AVG_EN
        conv_t      e, o;
        int         d;
        logic [7:0] avg_exp [3];
        avg_exp     = '{8'h20, 8'h38, 8'h4A};
        data_tbl[0] = 8'h80;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NCH; c++) begin
                d = $urandom_range(0, 40);
                model_step(d, e);
                run_conv(d, -1, o);
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL avg_conv_r%0d_c%0d: got %s | required %s", r, c, fmt(o), fmt(e));
                end
                if (c == 0) begin
                    n_checks++;
                    if (o.ch_data[7:0] !== avg_exp[r]) begin
                        n_fail++;
                        $display("FAIL avg_step%0d: got %h required %h", r, o.ch_data[7:0], avg_exp[r]);
                    end
                end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_conv();
        test_scan_wrap();
        test_timeout();
        test_early_eoc();
        test_boundaries();
        test_scan_en_drop();
        test_reset_abort();
        test_average();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
